// File: rtl/imm_gen_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_pkg
// Shared definitions for the immediate-generation pipeline stage.
//   - IMM_* : encodings of the 3-bit immediate format select (in_immsrc)
//   - occ_state_e : occupancy of the 2-entry skid buffer
// -----------------------------------------------------------------------------
package imm_gen_pipe_pkg;

    // Immediate format select encodings. 3'b110 and 3'b111 are reserved.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    // Number of entries currently held in the skid buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage : imm_gen_pipe_pkg

// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake bundle for imm_gen_pipe: an upstream (in_*) valid/ready channel
// carrying raw instructions and a downstream (out_*) valid/ready channel
// carrying extended immediates.
//
// Handshake rule (both channels): an item transfers on a rising clk edge
// where valid and ready are both high. A producer holding valid high keeps
// its payload stable until that transfer; ready never depends
// combinationally on the opposite channel's ready.
//
// Modports:
//   slave  : view of the pipeline block (consumes in_*, produces out_*)
//   master : view of the environment (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    // Upstream channel
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_immsrc;
    logic [TAG_W-1:0] in_tag;

    // Downstream channel
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_immsrc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

endinterface : imm_gen_pipe_if

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate decoder. Builds the 32-bit immediate for the
// selected format and sign-extends it to XLEN (XLEN = 32 or 64).
//
// Ports:
//   instr_i   [31:0]     instruction word
//   immsrc_i  [2:0]      format select (IMM_I .. IMM_Z, others reserved)
//   imm_o     [XLEN-1:0] extended immediate (0 for reserved formats)
//   illegal_o            high when immsrc_i is a reserved format
// -----------------------------------------------------------------------------
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      immsrc_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm32     = '0;
        illegal_o = 1'b0;
        unique case (immsrc_i)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            // CSR uimm: bit 31 of imm32 is zero, so the final sign
            // extension below leaves it zero-extended.
            IMM_Z: imm32 = {27'b0, instr_i[19:15]};
            default: begin
                imm32     = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

    // Every format above is already correct as a signed 32-bit value, so a
    // single sign extension to XLEN covers both the 32- and 64-bit builds.
    assign imm_o = XLEN'($signed(imm32));

endmodule : imm_decode

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// One pipeline stage that turns an instruction word into its extended
// immediate. Immediates are decoded on the way in and stored fully extended
// in a 2-entry skid buffer, so the output path is pure register reads.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (drops all buffered entries)
//   flush        synchronous kill: empties the buffer at the next edge and
//                discards any input offered in the same cycle
//   pipe_if      imm_gen_pipe_if.slave: in_* upstream, out_* downstream
//   dbg_state_o  current buffer occupancy (OCC_EMPTY / OCC_ONE / OCC_TWO)
//
// Buffer organisation:
//   head_q holds the oldest entry and drives the outputs directly.
//   skid_q holds the second entry only while the buffer is full.
//   Both registers are zeroed whenever they stop holding a live entry, so
//   the outputs read zero while out_valid is low without any output muxing.
//
// in_ready is a flop loaded with (next occupancy != TWO); it therefore has
// no combinational path from out_ready.
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_gen_pipe_if.slave       pipe_if,
    output occ_state_e          dbg_state_o
);

    typedef struct packed {
        logic             illegal;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  imm;
    } entry_t;

    occ_state_e state_q, state_d;
    entry_t     head_q,  head_d;
    entry_t     skid_q,  skid_d;
    logic       in_ready_q, in_ready_d;

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    entry_t          in_entry;
    logic            in_fire;
    logic            out_valid;
    logic            out_fire;

    // ------------------------------------------------------------------
    // Decode at the input so stored entries are already extended.
    // ------------------------------------------------------------------
    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .instr_i   (pipe_if.in_instr),
        .immsrc_i  (pipe_if.in_immsrc),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    assign in_entry = '{illegal: dec_illegal, tag: pipe_if.in_tag, imm: dec_imm};

    assign out_valid = (state_q != OCC_EMPTY);
    assign in_fire   = pipe_if.in_valid & in_ready_q;
    assign out_fire  = out_valid & pipe_if.out_ready;

    // ------------------------------------------------------------------
    // Occupancy FSM and entry movement.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (flush) begin
            // Flush wins over any handshake in the same cycle.
            state_d = OCC_EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        head_d  = in_entry;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    unique case ({in_fire, out_fire})
                        2'b11: head_d = in_entry;      // pass-through, stays ONE
                        2'b10: begin
                            skid_d  = in_entry;
                            state_d = OCC_TWO;
                        end
                        2'b01: begin
                            head_d  = '0;
                            state_d = OCC_EMPTY;
                        end
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_fire) begin
                        head_d  = skid_q;
                        skid_d  = '0;
                        state_d = OCC_ONE;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                    head_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end

        in_ready_d = (state_d != OCC_TWO);
    end

    // in_ready_q resets low and rises on the first edge after rst_n is
    // released, so nothing can be accepted while reset is still settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCC_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: straight from registers.
    // ------------------------------------------------------------------
    assign pipe_if.in_ready    = in_ready_q;
    assign pipe_if.out_valid   = out_valid;
    assign pipe_if.out_imm     = head_q.imm;
    assign pipe_if.out_tag     = head_q.tag;
    assign pipe_if.out_illegal = head_q.illegal;

    assign dbg_state_o = state_q;

endmodule : imm_gen_pipe

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Self-checking bench for imm_gen_pipe. A 32-bit instance is exercised with
// directed and randomized traffic against an arithmetic reference model and
// an expected-entry queue; a 64-bit instance covers the XLEN=64 formats.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    localparam int W = 38;   // {illegal, tag[4:0], imm[31:0]}

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       flush   = 1'b0;
    logic       flush64 = 1'b0;
    occ_state_e st32;
    occ_state_e st64;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    bit chk_en    = 1'b0;
    bit rand_rdy  = 1'b0;
    bit force_rdy = 1'b1;

    // compare-process scratch
    int           sb_sz;
    occ_state_e   sb_state;
    logic [W-1:0] sb_act;
    logic [64:0]  sb_m;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .pipe_if     (bus32.slave),
        .dbg_state_o (st32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush64),
        .pipe_if     (bus64.slave),
        .dbg_state_o (st64)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check helper
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: field arithmetic on the instruction value.
    // Returns {illegal, imm64}.
    // ------------------------------------------------------------------
    function automatic logic [64:0] model_imm(input logic [31:0] ins, input logic [2:0] src);
        longint w;
        longint v;
        logic   ill;
        w   = longint'({32'd0, ins});
        v   = 0;
        ill = 1'b0;
        case (src)
            3'd0: begin
                v = w >> 20;
                if (v >= 2048) v = v - 4096;
            end
            3'd1: begin
                v = ((w >> 25) << 5) + ((w >> 7) & 31);
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = ((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048
                  + ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2;
                if (v >= 4096) v = v - 8192;
            end
            3'd3: begin
                v = (w >> 12) * 4096;
                if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
            end
            3'd4: begin
                v = ((w >> 31) & 1) * 1048576 + ((w >> 12) & 255) * 4096
                  + ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            3'd5: v = (w >> 15) & 31;
            default: ill = 1'b1;
        endcase
        return {ill, 64'(v)};
    endfunction

    // ------------------------------------------------------------------
    // Downstream ready driver (single writer of bus32.out_ready)
    // ------------------------------------------------------------------
    initial begin
        bus32.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus32.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard / compare process: every negedge while enabled.
    // Queue length before this cycle's updates equals DUT occupancy.
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                sb_sz    = exp_q.size();
                sb_state = (sb_sz == 0) ? OCC_EMPTY : (sb_sz == 1) ? OCC_ONE : OCC_TWO;
                chk("occupancy", 64'(st32), 64'(sb_state));
                chk("out_valid", 64'(bus32.out_valid), 64'(sb_sz != 0));
                chk("in_ready",  64'(bus32.in_ready),  64'(sb_sz < 2));
                sb_act = {bus32.out_illegal, bus32.out_tag, bus32.out_imm};
                if (sb_sz != 0) chk("head_entry", 64'(sb_act), 64'(exp_q[0]));
                else            chk("idle_zero",  64'(sb_act), 64'd0);

                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (sb_sz != 0 && bus32.out_ready) void'(exp_q.pop_front());
                    if (bus32.in_valid && sb_sz < 2) begin
                        sb_m = model_imm(bus32.in_instr, bus32.in_immsrc);
                        exp_q.push_back({sb_m[64], bus32.in_tag, sb_m[31:0]});
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all start and end at posedge+1)
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
        int  n;
        bit  acc;
        n   = 0;
        acc = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = ins;
        bus32.in_immsrc = src;
        bus32.in_tag    = tag;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus32.in_ready && !flush;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready low for %0d cycles expected accept", n);
        end
        bus32.in_valid = 1'b0;
    endtask

    task automatic send_chk(input string name, input logic [31:0] ins, input logic [2:0] src,
                            input logic [31:0] exp_imm);
        send(ins, src, 5'h15);
        chk({name, "_valid"}, 64'(bus32.out_valid), 64'd1);
        chk({name, "_imm"},   64'(bus32.out_imm),   64'(exp_imm));
        chk({name, "_ill"},   64'(bus32.out_illegal), 64'd0);
    endtask

    task automatic flush_op();
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = $urandom;
        bus32.in_immsrc = 3'($urandom_range(0, 7));
        bus32.in_tag    = 5'($urandom);
        flush           = 1'b1;
        @(posedge clk);
        #1;
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("flush_state",     64'(st32), 64'(OCC_EMPTY));
    endtask

    task automatic dir64(input string name, input logic [31:0] ins, input logic [2:0] src,
                         input logic [63:0] exp_imm, input logic exp_ill);
        bus64.in_valid  = 1'b1;
        bus64.in_instr  = ins;
        bus64.in_immsrc = src;
        bus64.in_tag    = 5'h0A;
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        chk({name, "_valid"}, 64'(bus64.out_valid), 64'd1);
        chk({name, "_imm"},   bus64.out_imm, exp_imm);
        chk({name, "_ill"},   64'(bus64.out_illegal), 64'(exp_ill));
        chk({name, "_tag"},   64'(bus64.out_tag), 64'h0A);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [64:0] pin;

    initial begin
        bus32.in_valid  = 1'b0;
        bus32.in_instr  = '0;
        bus32.in_immsrc = '0;
        bus32.in_tag    = '0;
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = '0;
        bus64.in_immsrc = '0;
        bus64.in_tag    = '0;
        bus64.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rst_outputs",   64'({bus32.out_illegal, bus32.out_tag, bus32.out_imm}), 64'd0);
        chk("rst_state",     64'(st32), 64'(OCC_EMPTY));
        chk("rst_out_valid64", 64'(bus64.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst",   64'(bus32.in_ready), 64'd1);
        chk("ready_after_rst64", 64'(bus64.in_ready), 64'd1);
        chk_en = 1'b1;

        // Pin the reference model with hand-computed values
        pin = model_imm(32'hFFF00093, IMM_I);
        chk("pin_I", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        pin = model_imm(32'hFE000FA3, IMM_S);
        chk("pin_S", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        pin = model_imm(32'hFE000EE3, IMM_B);
        chk("pin_B", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
        pin = model_imm(32'h0080006F, IMM_J);
        chk("pin_J", pin[63:0], 64'h0000_0000_0000_0008);
        pin = model_imm(32'h12345037, IMM_U);
        chk("pin_U", pin[63:0], 64'h0000_0000_1234_5000);
        pin = model_imm(32'h80000037, IMM_U);
        chk("pin_U_neg", pin[63:0], 64'hFFFF_FFFF_8000_0000);
        pin = model_imm(32'h000F8073, IMM_Z);
        chk("pin_Z", pin[63:0], 64'h0000_0000_0000_001F);
        pin = model_imm(32'hFFFFFFFF, 3'b110);
        chk("pin_rsvd", 64'(pin), 64'd0);
        chk("pin_rsvd_ill", 64'(pin[64]), 64'd1);

        // Directed 32-bit formats, one cycle latency
        send_chk("dir_I", 32'hFFF00093, IMM_I, 32'hFFFF_FFFF);
        send_chk("dir_B", 32'hFE000EE3, IMM_B, 32'hFFFF_FFFC);
        send_chk("dir_J", 32'h0080006F, IMM_J, 32'h0000_0008);
        send_chk("dir_U", 32'h12345037, IMM_U, 32'h1234_5000);
        idle(2);

        // Directed 64-bit formats
        dir64("dir64_U",    32'h80000037, IMM_U,  64'hFFFF_FFFF_8000_0000, 1'b0);
        dir64("dir64_Z",    32'h000F8073, IMM_Z,  64'h0000_0000_0000_001F, 1'b0);
        dir64("dir64_rsvd", 32'hFFFFFFFF, 3'b110, 64'h0,                   1'b1);
        idle(2);

        // Stall: four entries with out_ready low for three cycles
        force_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send($urandom, 3'($urandom_range(0, 7)), 5'(10 + i));
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_in_ready", 64'(bus32.in_ready), 64'd0);
                chk("stall_state",    64'(st32), 64'(OCC_TWO));
                @(posedge clk);
                #1;
                force_rdy = 1'b1;
            end
        join
        idle(4);

        // Flush while full with an input offered
        force_rdy = 1'b0;
        send(32'h00500093, IMM_I, 5'h01);
        send(32'h00600093, IMM_I, 5'h02);
        chk("pre_flush_state", 64'(st32), 64'(OCC_TWO));
        flush_op();
        force_rdy = 1'b1;
        idle(4);

        // Randomized traffic with random back-pressure and occasional flush
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0)      flush_op();
            else if (r < 15) send($urandom, 3'($urandom_range(0, 7)), 5'($urandom));
            else             idle(1);
        end
        rand_rdy = 1'b0;
        idle(4);

        // Asynchronous reset mid-stream
        force_rdy = 1'b0;
        send(32'hABCDE0B7, IMM_U, 5'h1E);
        send(32'h7FF00093, IMM_I, 5'h1F);
        chk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",   64'(bus32.out_valid), 64'd0);
        chk("async_rst_state",   64'(st32), 64'(OCC_EMPTY));
        chk("async_rst_outputs", 64'({bus32.out_illegal, bus32.out_tag, bus32.out_imm}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        force_rdy = 1'b1;
        chk_en    = 1'b1;
        idle(5);

        // Post-reset traffic, then drain
        for (int i = 0; i < 20; i++)
            send($urandom, 3'($urandom_range(0, 7)), 5'($urandom));
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imm_gen_pipe

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-006 SHALL have port in_valid  input  1  upstream entry valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-008 SHALL have port in_instr  input  32  full instruction word.
REQ-009 SHALL have port in_immsrc  input  3  immediate format select.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-011 SHALL have port out_valid  output  1  head entry valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-013 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the head entry.
REQ-015 SHALL have port out_illegal  output  1  head entry used a reserved format.

Function
REQ-016 A transfer SHALL occur on a side when valid and ready are both high at a rising edge; no combinational path SHALL exist from out_ready to in_ready.
REQ-017 Storage SHALL be a 2-entry skid buffer with occupancy states EMPTY, ONE and TWO; in_ready = (state != TWO), registered.
REQ-018 Transitions: EMPTY->ONE on input transfer; ONE->TWO on input without output; ONE->EMPTY on output without input; TWO->ONE on output; every other combination holds state.
REQ-019 Latency SHALL be 1 cycle from input transfer to out_valid; throughput SHALL be 1 per cycle while out_ready is held high.
REQ-020 Ordering SHALL be FIFO; an entry SHALL NOT be dropped, duplicated or altered while out_valid is high and out_ready is low.
REQ-021 Immediates SHALL be computed at input and stored already extended, so the output path carries no extension logic.
REQ-022 Format 000 (I): sign-extend instr[31:20].
REQ-023 Format 001 (S): sign-extend {instr[31:25], instr[11:7]}.
REQ-024 Format 010 (B): sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-025 Format 011 (U): {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-026 Format 100 (J): sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-027 Format 101 (Z, CSR uimm): zero-extend instr[19:15].
REQ-028 Formats 110 and 111: imm = 0 and illegal = 1; every other format SHALL store illegal = 0.
REQ-029 flush SHALL empty the buffer at the next edge (state EMPTY, out_valid 0) and SHALL discard any input offered in that same cycle.
REQ-030 When out_valid is 0, out_imm, out_tag and out_illegal SHALL be 0.

Reset
REQ-031 While rst_n is low: state EMPTY, out_valid 0, out_imm/out_tag/out_illegal 0, in_ready 1 after the first edge following deassertion.
REQ-032 Assertion of rst_n mid-transfer SHALL discard all buffered entries immediately, without waiting for a clock edge.

Structure
REQ-033 Shared package SHALL hold the immsrc encodings (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z) and the occupancy state enum.
REQ-034 Format decode SHALL live in one combinational sub-module, imm_decode (instr, immsrc -> imm, illegal), parametrised by XLEN.

Verification
REQ-035 XLEN=32, I, instr 0xFFF00093 -> out_imm 0xFFFFFFFF one cycle later, illegal 0.
REQ-036 B, instr 0xFE000EE3 -> 0xFFFFFFFC; J, instr 0x0080006F -> 0x00000008; U, instr 0x12345037 -> 0x12345000.
REQ-037 XLEN=64, U, instr 0x80000037 -> 0xFFFFFFFF80000000; Z with instr[19:15]=5'h1F -> 0x1F; immsrc 110 -> imm 0, illegal 1.
REQ-038 Stream 4 entries with out_ready low for 3 cycles -> in_ready drops after 2 accepted, then all 4 emerge in order with tags intact.
REQ-039 flush asserted with state TWO and in_valid high -> next cycle out_valid 0, state EMPTY, offered entry never appears.
REQ-040 rst_n pulsed low mid-stream -> out_valid low immediately; no stale entry emerges after release.
